// File: rtl/umi_demux_pkg.sv
// umi_demux_pkg: shared types and constants for the buffered UMI demultiplexer
package umi_demux_pkg;

    localparam int FIFO_DEPTH = 2;

    typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_state_t;

    function automatic int selw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/umi_demux_fifo2.sv
// umi_demux_fifo2: two-entry valid/ready FIFO whose full flag comes only from registered state
module umi_demux_fifo2
    import umi_demux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic [W-1:0] mem [FIFO_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    // a pop in the same cycle does not open a slot for the incoming beat
    assign in_ready  = count != 2'(FIFO_DEPTH);
    assign out_valid = count != 2'd0;
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/umi_demux_buf.sv
// umi_demux_buf: buffered 1-to-N UMI demux; define UMI_DEMUX_ERR_EN to consume out-of-range beats and count them
module umi_demux_buf
    import umi_demux_pkg::*;
#(
    parameter int N       = 4,
    parameter int DW      = 256,
    parameter int CW      = 32,
    parameter int AW      = 64,
    parameter int SEL_LSB = 40
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            umi_in_valid,
    input  logic [CW-1:0]   umi_in_cmd,
    input  logic [AW-1:0]   umi_in_dstaddr,
    input  logic [AW-1:0]   umi_in_srcaddr,
    input  logic [DW-1:0]   umi_in_data,
    output logic            umi_in_ready,
    output logic [N-1:0]    umi_out_valid,
    output logic [N*CW-1:0] umi_out_cmd,
    output logic [N*AW-1:0] umi_out_dstaddr,
    output logic [N*AW-1:0] umi_out_srcaddr,
    output logic [N*DW-1:0] umi_out_data,
`ifdef UMI_DEMUX_ERR_EN
    output logic [15:0]     err_count,
    output logic            err_flag,
`endif
    input  logic [N-1:0]    umi_out_ready
);

    localparam int SELW = selw(N);
    localparam int NP   = 1 << SELW;
    localparam int W    = CW + 2*AW + DW;

    hold_state_t     state;
    logic [W-1:0]    hold_beat;
    logic [SELW-1:0] hold_idx;
    logic [SELW-1:0] sel;
    logic [SELW-1:0] in_idx;
    logic [N-1:0]    fifo_ready;
    logic [NP-1:0]   full_ext;
    logic            drain;
    logic            load;

    assign sel      = umi_in_dstaddr[SEL_LSB+:SELW];
    assign full_ext = NP'(~fifo_ready);

`ifdef UMI_DEMUX_ERR_EN
    logic hold_err;

    assign in_idx = sel;
    assign drain  = (state == HOLD_FULL) & (hold_err | ~full_ext[hold_idx]);

    always_ff @(posedge clk) begin
        if (load)
            hold_err <= 32'(sel) >= N;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= 16'd0;
            err_flag  <= 1'b0;
        end else if (drain & hold_err) begin
            err_flag <= 1'b1;
            if (err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end
`else
    assign in_idx = (32'(sel) >= N) ? SELW'(N - 1) : sel;
    assign drain  = (state == HOLD_FULL) & ~full_ext[hold_idx];
`endif

    // ready looks only at registered FIFO fullness, never at downstream ready
    assign umi_in_ready = ~reset & ((state == HOLD_EMPTY) | drain);
    assign load         = umi_in_valid & umi_in_ready;

    always_ff @(posedge clk) begin
        if (reset)
            state <= HOLD_EMPTY;
        else if (load)
            state <= HOLD_FULL;
        else if (drain)
            state <= HOLD_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (load) begin
            hold_beat <= {umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data};
            hold_idx  <= in_idx;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_port
        logic [W-1:0] head;

        umi_demux_fifo2 #(.W(W)) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (drain & (hold_idx == SELW'(i))),
            .in_data   (hold_beat),
            .in_ready  (fifo_ready[i]),
            .out_valid (umi_out_valid[i]),
            .out_data  (head),
            .out_ready (umi_out_ready[i])
        );

        assign {umi_out_cmd[i*CW+:CW], umi_out_dstaddr[i*AW+:AW],
                umi_out_srcaddr[i*AW+:AW], umi_out_data[i*DW+:DW]} = head;
    end

endmodule

// File: tb/tb_umi_demux_buf.sv
// tb_umi_demux_buf: randomized queue-model bench for umi_demux_buf plus directed routing, stall, reset and range cases
module tb_umi_demux_buf;

    localparam int N  = 4;
    localparam int CW = 32;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SL = 40;
    localparam int W  = CW + 2*AW + DW;

    typedef logic [W-1:0] beat_t;

    logic            clk = 0;
    logic            reset = 1;
    logic            in_valid = 0;
    logic [CW-1:0]   in_cmd = '0;
    logic [AW-1:0]   in_dst = '0;
    logic [AW-1:0]   in_src = '0;
    logic [DW-1:0]   in_data = '0;
    logic            in_ready;
    logic [N-1:0]    out_valid;
    logic [N*CW-1:0] out_cmd;
    logic [N*AW-1:0] out_dst;
    logic [N*AW-1:0] out_src;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]    out_ready = '1;

    logic            v3 = 0;
    logic [AW-1:0]   dst3 = '0;
    logic [DW-1:0]   data3 = '0;
    logic            in_ready3;
    logic [2:0]      o3_valid;
    logic [3*CW-1:0] o3_cmd;
    logic [3*AW-1:0] o3_dst;
    logic [3*AW-1:0] o3_src;
    logic [3*DW-1:0] o3_data;
    logic [2:0]      r3 = '1;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    started = 0;
    bit    any3 = 0;
    logic [DW-1:0] q3[$];

    beat_t mq[N][$];
    bit    hv;
    beat_t hb;
    int    hi;

`ifdef UMI_DEMUX_ERR_EN
    logic [15:0] err_cnt, err3_cnt;
    logic        err_flg, err3_flg;
`endif

    umi_demux_buf #(.N(N), .DW(DW), .CW(CW), .AW(AW), .SEL_LSB(SL)) dut (
        .clk(clk), .reset(reset),
        .umi_in_valid(in_valid), .umi_in_cmd(in_cmd), .umi_in_dstaddr(in_dst),
        .umi_in_srcaddr(in_src), .umi_in_data(in_data), .umi_in_ready(in_ready),
        .umi_out_valid(out_valid), .umi_out_cmd(out_cmd), .umi_out_dstaddr(out_dst),
        .umi_out_srcaddr(out_src), .umi_out_data(out_data),
`ifdef UMI_DEMUX_ERR_EN
        .err_count(err_cnt), .err_flag(err_flg),
`endif
        .umi_out_ready(out_ready)
    );

    umi_demux_buf #(.N(3), .DW(DW), .CW(CW), .AW(AW), .SEL_LSB(SL)) dut3 (
        .clk(clk), .reset(reset),
        .umi_in_valid(v3), .umi_in_cmd(32'h33), .umi_in_dstaddr(dst3),
        .umi_in_srcaddr(64'h5), .umi_in_data(data3), .umi_in_ready(in_ready3),
        .umi_out_valid(o3_valid), .umi_out_cmd(o3_cmd), .umi_out_dstaddr(o3_dst),
        .umi_out_srcaddr(o3_src), .umi_out_data(o3_data),
`ifdef UMI_DEMUX_ERR_EN
        .err_count(err3_cnt), .err_flag(err3_flg),
`endif
        .umi_out_ready(r3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input beat_t act, input beat_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic int route(input logic [AW-1:0] d);
        int s;
        s = int'(d[SL+:2]);
        return (s >= N) ? N - 1 : s;
    endfunction

    function automatic beat_t port_beat(input int i);
        return {out_cmd[i*CW+:CW], out_dst[i*AW+:AW], out_src[i*AW+:AW], out_data[i*DW+:DW]};
    endfunction

    // reference: a one-beat holding slot feeding per-port queues capped at two
    always @(posedge clk) begin : model
        bit drain;
        bit acc;
        if (reset) begin
            started = 1;
            hv = 0;
            for (int i = 0; i < N; i++) mq[i].delete();
        end else begin
            drain = hv && mq[hi].size() < 2;
            acc = in_valid && (!hv || drain);
            for (int i = 0; i < N; i++)
                if (mq[i].size() != 0 && out_ready[i]) void'(mq[i].pop_front());
            if (drain) mq[hi].push_back(hb);
            if (acc) begin
                hb = {in_cmd, in_dst, in_src, in_data};
                hi = route(in_dst);
                hv = 1;
            end else if (drain) begin
                hv = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        if (started) begin
            chk("in_ready", W'(in_ready), W'(!reset && (!hv || mq[hi].size() < 2)));
            for (int i = 0; i < N; i++) begin
                chk($sformatf("out_valid[%0d]", i), W'(out_valid[i]), W'(mq[i].size() != 0));
                if (mq[i].size() != 0)
                    chk($sformatf("payload[%0d]", i), port_beat(i), mq[i][0]);
            end
        end
    end

    always @(negedge clk) begin
        if (started && !reset) begin
            if (o3_valid !== 3'b000) any3 = 1;
            if (o3_valid[2] && r3[2]) q3.push_back(o3_data[2*DW+:DW]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int port, input logic [DW-1:0] d);
        bit f = 0;
        in_valid = 1;
        in_cmd = $urandom;
        in_src = {$urandom, $urandom};
        in_dst = {$urandom, $urandom};
        in_dst[SL+:2] = 2'(port);
        in_data = d;
        for (int k = 0; k < 500 && !f; k++) begin
            @(negedge clk);
            f = in_valid && in_ready;
            step();
        end
        if (!f) begin
            checks++;
            errors++;
            $display("FAIL put_timeout port %0d: no handshake, required one within 500 cycles", port);
        end
        in_valid = 0;
    endtask

    task automatic put3(input logic [DW-1:0] d);
        bit f = 0;
        v3 = 1;
        dst3 = {$urandom, $urandom};
        dst3[SL+:2] = 2'd3;
        data3 = d;
        for (int k = 0; k < 50 && !f; k++) begin
            @(negedge clk);
            f = v3 && in_ready3;
            step();
        end
        if (!f) begin
            checks++;
            errors++;
            $display("FAIL put3_timeout: no handshake, required one within 50 cycles");
        end
        v3 = 0;
    endtask

    initial begin
        #1_500_000;
        checks++;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin : main
        logic [DW-1:0] got2[$];
        logic [DW-1:0] got0;
        bit            f;
        bit            done;
        int            c0;
        repeat (3) step();
        chk("reset_in_ready", W'(in_ready), W'(0));
        chk("reset_out_valid", W'(out_valid), W'(0));
        reset = 0;
        @(negedge clk);
        chk("ready_after_reset", W'(in_ready), W'(1));
        step();

        for (int i = 0; i < N; i++) begin
            put(i, DW'(32'hA0 + i));
            @(negedge clk);
            chk("route_latency", W'(out_valid), W'(0));
            @(negedge clk);
            chk("route_valid", W'(out_valid), W'(1 << i));
            chk("route_data", W'(out_data[i*DW+:DW]), W'(32'hA0 + i));
            step();
        end

        out_ready = 4'b1011;
        put(2, 64'hB0);
        put(2, 64'hB1);
        put(2, 64'hB2);
        @(negedge clk);
        chk("bp_in_ready", W'(in_ready), W'(0));
        chk("bp_out_valid", W'(out_valid), W'(4'b0100));
        step();
        in_valid = 1;
        in_dst = '0;
        in_data = 64'hC0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hol_block", W'(in_ready), W'(0));
            step();
        end
        out_ready = '1;
        got0 = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid[2]) got2.push_back(out_data[2*DW+:DW]);
            if (out_valid[0]) got0 = out_data[0+:DW];
            f = in_valid && in_ready;
            step();
            if (f) in_valid = 0;
        end
        chk("bp_count", W'(got2.size()), W'(3));
        for (int k = 0; k < 3 && k < got2.size(); k++)
            chk("bp_order", W'(got2[k]), W'(64'hB0 + k));
        chk("bp_released", W'(got0), W'(64'hC0));

        c0 = cyc;
        for (int k = 0; k < 100; k++) put(k % 2, DW'(k));
        chk("throughput_cycles", W'(cyc - c0), W'(100));
        repeat (3) step();

        out_ready = 4'b0111;
        put(3, 64'hD0);
        put(3, 64'hD1);
        step();
        @(negedge clk);
        chk("pre_reset_valid", W'(out_valid), W'(4'b1000));
        step();
        reset = 1;
        step();
        chk("mid_reset_valid", W'(out_valid), W'(0));
        chk("mid_reset_ready", W'(in_ready), W'(0));
        reset = 0;
        out_ready = '1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("no_stale", W'(out_valid), W'(0));
            step();
        end

        done = 0;
        fork
            begin
                for (int n = 0; n < 10000; n++) begin
                    if ($urandom_range(0, 3) == 0) step();
                    put($urandom_range(0, N - 1), {$urandom, $urandom});
                end
                done = 1;
            end
            begin
                int mode;
                int stall;
                for (int c = 0; !done; c++) begin
                    if (c % 64 == 0) begin
                        mode = $urandom_range(0, 5);
                        stall = $urandom_range(0, N - 1);
                    end
                    out_ready = (mode < 3) ? '1 :
                                (mode < 5) ? (N'($urandom) | N'($urandom)) : ~(N'(1) << stall);
                    step();
                end
            end
        join
        out_ready = '1;
        repeat (10) step();
        chk("final_empty", W'(out_valid), W'(0));

`ifdef UMI_DEMUX_ERR_EN
        chk("err_init", W'({err3_flg, err3_cnt}), W'(0));
`endif
        put3(64'hE0);
        put3(64'hE1);
        repeat (6) step();
`ifdef UMI_DEMUX_ERR_EN
        chk("range_no_valid", W'(any3), W'(0));
        chk("range_err_count", W'(err3_cnt), W'(2));
        chk("range_err_flag", W'(err3_flg), W'(1));
        chk("inrange_err_count", W'(err_cnt), W'(0));
`else
        chk("range_count", W'(q3.size()), W'(2));
        for (int k = 0; k < 2 && k < q3.size(); k++)
            chk("range_data", W'(q3[k]), W'(64'hE0 + k));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
